// File: rtl/mc_core_pkg.sv
// Shared definitions for the mc_core multi-cycle processor: instruction
// field positions, opcode encodings, FSM state type and opcode helpers.
package mc_core_pkg;

  localparam int INSN_W = 32;
  localparam int IMM_W  = 12;

  // Instruction field slice positions.
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 27;
  localparam int RD_LO  = 22;
  localparam int IMM_HI = 21;
  localparam int IMM_LO = 10;
  localparam int RS2_LO = 5;
  localparam int RS1_LO = 0;

  // Opcode encodings.
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_OR    = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_SHL   = 5'b00110;
  localparam logic [4:0] OP_SHR   = 5'b00111;
  localparam logic [4:0] OP_LDI   = 5'b01000;
  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b10001;
  localparam logic [4:0] OP_JMP   = 5'b11000;
  localparam logic [4:0] OP_BEQ   = 5'b11001;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  // True for every defined opcode; anything else runs as a NOP and flags illegal.
  function automatic logic op_is_legal(input logic [4:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
      OP_LDI, OP_LOAD, OP_STORE, OP_JMP, OP_BEQ, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // True for opcodes that write rd in writeback.
  function automatic logic op_writes_rd(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
      OP_LDI, OP_LOAD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_core_alu.sv
// Combinational ALU: ADD..SHR on two register operands plus LDI immediate
// pass-through. Arithmetic wraps mod 2^DATA_W.
module mc_core_alu
  import mc_core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;

  // Shift distance uses only the low log2(DATA_W) bits of the second operand.
  assign shamt = b[SH_W-1:0];

  // Select the result for the decoded opcode.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves y unassigned and no latch is inferred.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << shamt;
      OP_SHR:  y = a >> shamt;
      OP_LDI:  y = imm;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle processor core: FETCH/DECODE/EXEC/MEM/WB sequenced by an FSM,
// internal register file, req/ack instruction and data memory ports.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int PC_W     = 5,
  parameter int DADDR_W  = 5,
  parameter int RESET_PC = 0
) (
  input  logic               clock,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSN_W-1:0]  imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               retire,
  output logic [PC_W-1:0]    retire_pc,
  output logic               illegal,
  output logic               halted
);

  localparam int RIDX_W = $clog2(NREG);
  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  state_e state_q, state_d;

  logic [PC_W-1:0]    pc_q, npc_q, next_pc;
  logic [INSN_W-1:0]  ir_q;
  logic [DATA_W-1:0]  a_q, b_q, res_q, dwdata_q;
  logic [DADDR_W-1:0] daddr_q;
  logic [DATA_W-1:0]  rf_q [NREG];

  logic [4:0]              op;
  logic [RIDX_W-1:0]       rd_idx, rs1_idx, rs2_idx;
  logic signed [IMM_W-1:0] imm_s;
  logic [DATA_W-1:0]       imm_d, rs1_val, rs2_val, alu_y;
  logic [PC_W-1:0]         imm_pc, jmp_pc;
  logic                    is_mem, is_store;

  // Field extraction from the captured instruction word.
  assign op      = ir_q[OP_HI:OP_LO];
  assign rd_idx  = ir_q[RD_LO +: RIDX_W];
  assign rs2_idx = ir_q[RS2_LO +: RIDX_W];
  assign rs1_idx = ir_q[RS1_LO +: RIDX_W];
  assign imm_s   = ir_q[IMM_HI:IMM_LO];
  assign imm_d   = DATA_W'(imm_s);
  assign imm_pc  = PC_W'(imm_s);
  assign jmp_pc  = PC_W'(ir_q[IMM_HI:IMM_LO]);

  assign is_store = (op == OP_STORE);
  assign is_mem   = (op == OP_LOAD) || is_store;

  // Register 0 always reads as zero.
  assign rs1_val = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

  mc_core_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op),
    .a   (a_q),
    .b   (b_q),
    .imm (imm_d),
    .y   (alu_y)
  );

  // Next pc: jump target, taken-branch target, or sequential; all wrap mod 2^PC_W.
  always_comb begin
    next_pc = pc_q + PC_W'(1);
    if (op == OP_JMP) begin
      next_pc = jmp_pc;
    end else if (op == OP_BEQ && a_q == b_q) begin
      next_pc = pc_q + imm_pc;
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values and updates together, independent of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/status outputs; imem_req is gated by rst_n so it
  // drops the moment reset asserts, abandoning any pending fetch.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = rst_n;
        if (imem_ack) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = is_mem ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) state_d = WB;
      end
      WB: begin
        retire  = 1'b1;
        illegal = !op_is_legal(op);
        state_d = (op == OP_HALT) ? HALT : FETCH;
      end
      HALT:    halted  = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  // Address/data outputs are zero whenever their qualifier is low.
  assign imem_addr  = rst_n ? pc_q : '0;
  assign dmem_addr  = dmem_req ? daddr_q : '0;
  assign dmem_wdata = dmem_req ? dwdata_q : '0;
  assign retire_pc  = retire ? pc_q : '0;

  // Datapath registers: instruction, operands, result, memory request, pc.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_RST;
      npc_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      daddr_q  <= '0;
      dwdata_q <= '0;
    end else begin
      case (state_q)
        FETCH:  if (imem_ack) ir_q <= imem_rdata;
        DECODE: begin
          a_q <= rs1_val;
          b_q <= rs2_val;
        end
        EXEC: begin
          res_q    <= alu_y;
          daddr_q  <= DADDR_W'(a_q + imm_d);
          dwdata_q <= b_q;
          npc_q    <= next_pc;
        end
        MEM:     if (dmem_ack && !is_store) res_q <= dmem_rdata;
        WB:      pc_q <= npc_q;
        default: ;
      endcase
    end
  end

  // Register file write in writeback; writes to register 0 are dropped.
  // NOTE: this array is reset explicitly because every register must read 0
  // after reset, which also keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (state_q == WB && op_writes_rd(op) && rd_idx != '0) begin
      rf_q[rd_idx] <= res_q;
    end
  end

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multi-cycle processor core: fetch, decode, execute, memory and writeback run as sequential FSM states over one 32-bit instruction format. It owns an internal register file and talks to separate instruction and data memories through req/ack handshakes, so wait-state memories work. It generalises the fixed 32-bit/32-entry core with configurable data width, register count and PC width, plus load/store, immediates, branches, halt and an illegal-opcode flag.

## Interface
- DATA_W, 32: datapath/register width, ≥8.
- NREG, 32: register count, power of two, 2..32; index = low log2(NREG) bits of each 5-bit field.
- PC_W, 5: instruction address width; the PC wraps mod 2^PC_W.
- DADDR_W, 5: data address width.
- RESET_PC, 0: PC value loaded at reset.
- clock  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  instruction valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  access complete; load data valid.
- dmem_rdata  in  DATA_W  load data.
- retire  out  1  one-cycle pulse per completed instruction.
- retire_pc  out  PC_W  PC of the retiring instruction.
- illegal  out  1  one-cycle pulse with retire for an undefined opcode.
- halted  out  1  high in HALT state.

## Operation
- Format: op=ir[31:27], rd=ir[26:22], imm=ir[21:10] (12-bit, sign-extended to DATA_W/PC_W), rs2=ir[9:5], rs1=ir[4:0].
- Register 0 reads zero; writes to it are dropped.
- Opcodes: 00000 NOP; 00001 ADD; 00010 SUB; 00011 AND; 00100 OR; 00101 XOR; 00110 SHL; 00111 SHR (logical). Shift amount = low log2(DATA_W) bits of r[rs2]. Arithmetic is mod 2^DATA_W and carries are discarded.
- 01000 LDI: rd = sext(imm).
- 10000 LOAD: rd = mem[r[rs1]+sext(imm)].
- 10001 STORE: mem[r[rs1]+sext(imm)] = r[rs2]. The address is truncated to DADDR_W.
- 11000 JMP: pc = imm[PC_W-1:0].
- 11001 BEQ: if r[rs1]==r[rs2], pc = pc+sext(imm); otherwise pc+1.
- 11111 HALT: enter HALT. `halted` stays 1 until reset, and no further requests are issued.
- Any other opcode executes as NOP and pulses `illegal`.
- FSM transitions:
  - FETCH → DECODE on imem_ack.
  - DECODE → EXEC.
  - EXEC → MEM for LOAD/STORE; EXEC → WB otherwise.
  - MEM → WB on dmem_ack.
  - WB → FETCH, or WB → HALT for HALT.
- Register reads happen in DECODE. The ALU result is registered in EXEC. Register write, pc update and `retire` all happen in WB.

## Timing
- Reset (async assert, sync release): state=FETCH, pc=RESET_PC, all registers 0. Every output is 0 while rst_n=0.
- imem_req rises in the first cycle after release.
- In FETCH, imem_req=1 and imem_addr=pc are held stable until the cycle in which imem_ack=1. ir is captured at that edge, and imem_req drops the next cycle.
- In MEM, dmem_req/we/addr/wdata are held stable until dmem_ack. For a LOAD, dmem_rdata is captured at the ack edge.
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU, LDI, JMP, BEQ, NOP: 4 cycles, req to next req.
  - LOAD and STORE: 5 cycles.
  - Each memory wait cycle adds exactly 1.
- An ack seen while the matching req=0 is ignored.
- Back-to-back dependent instructions need no forwarding: writeback completes before the next DECODE.
- pc+1 at 2^PC_W−1 wraps to 0. A BEQ offset wraps the same way.
- Reset mid-transaction abandons the outstanding request. req drops asynchronously, and the memory must tolerate this.

## Structure
- Package `mc_core_pkg` holds:
  - opcode localparams;
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - field slice positions.
- One sub-module, `mc_core_alu`: combinational, DATA_W-parametrised, implementing ADD..SHR and LDI pass-through.
- The register file and FSM stay in `mc_core`.

## Test plan
- LDI r1,5; LDI r2,7; ADD r3,r1,r2; STORE r3→[0+2] → dmem write with addr=2, wdata=12; retire every 4th cycle except 5 for the STORE.
- DATA_W=8: LDI r1,−1 (0xFF); ADD r2,r1,r1 → r2=0xFE. SHL by r[rs2]=9 → shift by 1.
- imem_ack delayed 3 cycles, dmem_ack delayed 2 cycles on a LOAD → req/addr held stable throughout; LOAD retires at 5+3+2 cycles.
- BEQ taken with imm=−1 at pc=0, PC_W=5 → next fetch addr 31. BEQ not taken → addr 1. JMP imm=9 → addr 9.
- Opcode 10101 → illegal and retire pulse together, no register write. HALT → halted=1 and no imem_req for 20 cycles.
- rst_n pulled low mid-FETCH with imem_ack pending → outputs 0 immediately; after release, fetch restarts at RESET_PC.
